// File: rtl/card_grid_compositor.sv
// Memory-card board pixel compositor: ROWS x COLS cards, per-card symbol/state, 3-stage pixel pipe.
// Optional cursor blinking is enabled with `define CURSOR_BLINK_EN.
module card_grid_compositor #(
  parameter int         ROWS     = 4,
  parameter int         COLS     = 4,
  parameter int         ORG_X    = 72,
  parameter int         ORG_Y    = 40,
  parameter int         CARD_W   = 96,
  parameter int         CARD_H   = 96,
  parameter int         PITCH_X  = 128,
  parameter int         PITCH_Y  = 112,
  parameter int         BORDER   = 2,
  parameter int         VACT     = 480,
  parameter logic [8:0] BG_RGB   = 9'h000,
  parameter logic [8:0] BACK_RGB = 9'h0C4,
  parameter logic [8:0] CUR_RGB  = 9'h1F8,
  parameter int         IDX_W    = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [3:0]       cmd_sym,
  output logic             cmd_err,
  input  logic [IDX_W-1:0] cursor_idx,
  output logic [IDX_W:0]   up_count,
  output logic [IDX_W:0]   matched_count,
  output logic [8:0]       rgb
);

  localparam int N    = ROWS * COLS;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W:0] ONE = 1;

  typedef enum logic [1:0] {ST_DOWN = 2'd0, ST_UP = 2'd1, ST_MATCHED = 2'd2} card_st_t;

  function automatic logic [8:0] palette(input logic [3:0] s);
    case (s)
      4'd0:    palette = 9'h1C0;
      4'd1:    palette = 9'h038;
      4'd2:    palette = 9'h007;
      4'd3:    palette = 9'h1B6;
      4'd4:    palette = 9'h03F;
      4'd5:    palette = 9'h1C7;
      4'd6:    palette = 9'h124;
      4'd7:    palette = 9'h092;
      4'd8:    palette = 9'h049;
      4'd9:    palette = 9'h1A4;
      4'd10:   palette = 9'h0E0;
      4'd11:   palette = 9'h01C;
      4'd12:   palette = 9'h103;
      4'd13:   palette = 9'h150;
      4'd14:   palette = 9'h0AA;
      default: palette = 9'h155;
    endcase
  endfunction

  card_st_t        r_state [0:N-1];
  logic [3:0]      r_sym   [0:N-1];
  logic [IDX_W:0]  r_up, r_mt;
  logic            r_err;

  logic            w_accept, w_idx_ok, w_wr, w_rej;
  card_st_t        w_cur_st, w_new_st;
  logic [IDX_W:0]  w_up_nx, w_mt_nx;

  assign cmd_ready     = ({2'b00, VCount} >= 12'(VACT));
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_idx_ok      = (32'(cmd_idx) < N);
  assign w_cur_st      = w_idx_ok ? r_state[cmd_idx] : ST_DOWN;
  assign cmd_err       = r_err;
  assign up_count      = r_up;
  assign matched_count = r_mt;

  always_comb begin
    w_wr     = 1'b0;
    w_rej    = 1'b0;
    w_new_st = ST_DOWN;
    w_up_nx  = r_up;
    w_mt_nx  = r_mt;
    if (w_accept) begin
      if (!w_idx_ok) begin
        w_rej = 1'b1;
      end else begin
        case (cmd_op)
          2'd0: begin
            w_wr = 1'b1;
            if (w_cur_st == ST_UP)      w_up_nx = r_up - ONE;
            if (w_cur_st == ST_MATCHED) w_mt_nx = r_mt - ONE;
          end
          2'd1: begin
            if (w_cur_st == ST_DOWN) begin
              w_wr     = 1'b1;
              w_new_st = ST_UP;
              w_up_nx  = r_up + ONE;
            end else w_rej = 1'b1;
          end
          2'd2: begin
            if (w_cur_st == ST_UP) begin
              w_wr    = 1'b1;
              w_up_nx = r_up - ONE;
            end else w_rej = 1'b1;
          end
          default: begin
            if (w_cur_st == ST_UP) begin
              w_wr     = 1'b1;
              w_new_st = ST_MATCHED;
              w_up_nx  = r_up - ONE;
              w_mt_nx  = r_mt + ONE;
            end else w_rej = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_DOWN;
        r_sym[i]   <= 4'd0;
      end
      r_up  <= '0;
      r_mt  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_rej;
      r_up  <= w_up_nx;
      r_mt  <= w_mt_nx;
      if (w_wr) begin
        r_state[cmd_idx] <= w_new_st;
        if (cmd_op == 2'd0) r_sym[cmd_idx] <= cmd_sym;
      end
    end
  end

  // S1: per-column / per-row window comparators; edge flags only matter where the window hits
  logic [COLS-1:0] w_col_hit, w_col_edge, r_col_hit;
  logic [ROWS-1:0] w_row_hit, w_row_edge, r_row_hit;
  logic            r_border1;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int X0 = ORG_X + gi * PITCH_X;
      assign w_col_hit[gi]  = ({2'b00, HCount} >= 12'(X0)) && ({2'b00, HCount} < 12'(X0 + CARD_W));
      assign w_col_edge[gi] = ({2'b00, HCount} < 12'(X0 + BORDER)) ||
                              ({2'b00, HCount} >= 12'(X0 + CARD_W - BORDER));
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam int Y0 = ORG_Y + gi * PITCH_Y;
      assign w_row_hit[gi]  = ({2'b00, VCount} >= 12'(Y0)) && ({2'b00, VCount} < 12'(Y0 + CARD_H));
      assign w_row_edge[gi] = ({2'b00, VCount} < 12'(Y0 + BORDER)) ||
                              ({2'b00, VCount} >= 12'(Y0 + CARD_H - BORDER));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_hit <= '0;
      r_row_hit <= '0;
      r_border1 <= 1'b0;
    end else begin
      r_col_hit <= w_col_hit;
      r_row_hit <= w_row_hit;
      r_border1 <= (|(w_col_hit & w_col_edge)) || (|(w_row_hit & w_row_edge));
    end
  end

  // S2: one-hot hits to card index, then fetch that card's state/symbol
  logic [CW-1:0]    w_col_sel;
  logic [RW-1:0]    w_row_sel;
  logic             w_on;
  logic [IDX_W-1:0] w_pix_idx;

  always_comb begin
    w_col_sel = '0;
    w_row_sel = '0;
    for (int c = 0; c < COLS; c++) if (r_col_hit[c]) w_col_sel = CW'(c);
    for (int r = 0; r < ROWS; r++) if (r_row_hit[r]) w_row_sel = RW'(r);
  end

  assign w_on      = (|r_col_hit) && (|r_row_hit);
  assign w_pix_idx = IDX_W'(32'(w_row_sel) * COLS + 32'(w_col_sel));

  logic       r_on2, r_border2, r_cur2;
  card_st_t   r_st2;
  logic [3:0] r_sym2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on2     <= 1'b0;
      r_border2 <= 1'b0;
      r_cur2    <= 1'b0;
      r_st2     <= ST_DOWN;
      r_sym2    <= 4'd0;
    end else begin
      r_on2     <= w_on;
      r_border2 <= r_border1;
      r_cur2    <= (w_pix_idx == cursor_idx);
      r_st2     <= w_on ? r_state[w_pix_idx] : ST_DOWN;
      r_sym2    <= w_on ? r_sym[w_pix_idx] : 4'd0;
    end
  end

  logic w_cur_vis;
`ifdef CURSOR_BLINK_EN
  logic [5:0] r_frame;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame <= 6'd0;
    else if (({2'b00, VCount} == 12'(VACT)) && (HCount == 10'd0)) r_frame <= r_frame + 6'd1;
  end
  assign w_cur_vis = ~r_frame[5];
`else
  assign w_cur_vis = 1'b1;
`endif

  // S3: colour priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= BG_RGB;
    end else if (!r_on2 || r_st2 == ST_MATCHED) begin
      rgb <= BG_RGB;
    end else if (r_border2 && r_cur2 && w_cur_vis) begin
      rgb <= CUR_RGB;
    end else if (r_border2) begin
      rgb <= 9'h1FF;
    end else if (r_st2 == ST_DOWN) begin
      rgb <= BACK_RGB;
    end else begin
      rgb <= palette(r_sym2);
    end
  end

endmodule
